// File: rtl/pe_part_sum_bcast_ctrl_pkg.sv
// Shared constants for the partial-sum broadcaster: FSM state encoding,
// output FIFO geometry and default bus widths (match the pe/router buses).
package pe_part_sum_bcast_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam int unsigned PSUM_FIFO_DEPTH = 2;
  localparam int unsigned PSUM_FIFO_CNT_W = 2;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_RANK_WIDTH = 6;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_PIPE_DELAY = 3;

endpackage

// File: rtl/pe_part_sum_bcast_ctrl_fifo.sv
// psum_bcast_fifo: 2-entry {addr, data} FIFO for the partial-sum broadcaster.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clr_i               synchronous clear (pass abort)
//   push_i / din_i      write one entry
//   pop_i  / dout_o     head entry, removed on pop
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries
module psum_bcast_fifo
  import pe_part_sum_bcast_ctrl_pkg::*;
#(
  parameter type entry_t = logic [7:0]
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  entry_t                     din_i,
  output entry_t                     dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [PSUM_FIFO_CNT_W-1:0] count_o
);

  // Depth is fixed at 2, so single-bit pointers suffice.
  entry_t                     mem_q [PSUM_FIFO_DEPTH];
  logic                       wr_ptr_q;
  logic                       rd_ptr_q;
  logic [PSUM_FIFO_CNT_W-1:0] cnt_q;
  logic                       push_ok;
  logic                       pop_ok;

  assign full_o  = (cnt_q == PSUM_FIFO_CNT_W'(PSUM_FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  // Storage is cleared too so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      for (int unsigned i = 0; i < PSUM_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + PSUM_FIFO_CNT_W'(push_ok) - PSUM_FIFO_CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/pe_part_sum_bcast_ctrl.sv
// pe_part_sum_bcast_ctrl: counts delayed partial-sum completions, reads the
// finished sums from the output-activation register file (1-cycle latency)
// and streams {base+index, data} to the network interface via valid/ready.
// Optional feature macro: PSUM_BCAST_SKIP_ZERO_EN (drop zero-valued sums).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   pe_idx                     PE index (informational only)
//   part_sum_done              completion pulse; starts a pass in IDLE
//   rank_no, base_addr         pass length / destination base, sampled on start
//   abort                      synchronous cancel of the current pass
//   busy, fin_tx_part_sum      status, end-of-pass pulse
//   rd_en, rd_addr, rd_data    register-file secondary read port
//   send_valid/ready/data/addr network-interface stream
module pe_part_sum_bcast_ctrl
  import pe_part_sum_bcast_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RANK_WIDTH = DEF_RANK_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            pe_idx,
  input  logic                  part_sum_done,
  input  logic [RANK_WIDTH-1:0] rank_no,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  abort,
  output logic                  busy,
  output logic                  fin_tx_part_sum,
  output logic                  rd_en,
  output logic [RANK_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  send_valid,
  input  logic                  send_ready,
  output logic [DATA_WIDTH-1:0] send_data,
  output logic [ADDR_WIDTH-1:0] send_addr
);

  localparam int unsigned CW = RANK_WIDTH + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_e                state_q, state_d;
  logic [PIPE_DELAY-1:0] done_sr_q, done_sr_d;
  logic [CW-1:0]         done_cnt_q, done_cnt_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [RANK_WIDTH-1:0] rank_q, rank_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  infl_q;
  logic [RANK_WIDTH-1:0] infl_idx_q;

  logic                       done_dly;
  logic [CW-1:0]              rank_ext;
  logic                       rd_issue;
  logic                       fin_pulse;
  logic                       fifo_clr;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [PSUM_FIFO_CNT_W-1:0] fifo_count;
  logic [2:0]                 occ;
  logic                       credit_ok;
  entry_t                     fifo_din;
  entry_t                     fifo_head;
  logic                       unused_ok;

  assign done_dly = done_sr_q[PIPE_DELAY-1];
  assign rank_ext = CW'(rank_q);
  assign fifo_pop = send_valid && send_ready;

  // Credit counts the slot freed by a pop this cycle, so a steady stream
  // with send_ready high sustains one read per cycle.
  assign occ       = 3'(fifo_count) + 3'(infl_q) - 3'(fifo_pop);
  assign credit_ok = (occ < 3'(PSUM_FIFO_DEPTH));

  // Next-state / output decode
  always_comb begin
    state_d    = state_q;
    done_cnt_d = done_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    rank_d     = rank_q;
    base_d     = base_q;
    done_sr_d  = PIPE_DELAY'({done_sr_q, part_sum_done});
    rd_issue   = 1'b0;
    fin_pulse  = 1'b0;
    fifo_clr   = 1'b0;

    if (state_q != ST_IDLE && done_dly && done_cnt_q < rank_ext)
      done_cnt_d = done_cnt_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (part_sum_done) begin
          done_cnt_d = '0;
          rd_cnt_d   = '0;
          rank_d     = rank_no;
          base_d     = base_addr;
          state_d    = (rank_no == '0) ? ST_DRAIN : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (done_cnt_q > rd_cnt_q && rd_cnt_q < rank_ext && credit_ok) begin
          rd_issue = 1'b1;
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_cnt_q == rank_ext - CW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !infl_q) begin
          fin_pulse = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start.
    if (abort) begin
      state_d    = ST_IDLE;
      done_cnt_d = '0;
      rd_cnt_d   = '0;
      done_sr_d  = '0;
      rd_issue   = 1'b0;
      fin_pulse  = 1'b0;
      fifo_clr   = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      done_sr_q  <= '0;
      done_cnt_q <= '0;
      rd_cnt_q   <= '0;
      rank_q     <= '0;
      base_q     <= '0;
      infl_q     <= 1'b0;
      infl_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      done_sr_q  <= done_sr_d;
      done_cnt_q <= done_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rank_q     <= rank_d;
      base_q     <= base_d;
      infl_q     <= rd_issue;
      infl_idx_q <= rd_cnt_q[RANK_WIDTH-1:0];
    end
  end

  // Read return: address wraps modulo 2^ADDR_WIDTH.
`ifdef PSUM_BCAST_SKIP_ZERO_EN
  assign fifo_push = infl_q && !abort && (rd_data != '0);
`else
  assign fifo_push = infl_q && !abort;
`endif
  assign fifo_din.addr = base_q + ADDR_WIDTH'(infl_idx_q);
  assign fifo_din.data = rd_data;

  psum_bcast_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy            = (state_q != ST_IDLE);
  assign fin_tx_part_sum = fin_pulse;
  assign rd_en           = rd_issue;
  assign rd_addr         = rd_issue ? rd_cnt_q[RANK_WIDTH-1:0] : '0;
  assign send_valid      = !fifo_empty;
  assign send_data       = fifo_head.data;
  assign send_addr       = fifo_head.addr;

  // pe_idx is informational; full is implied by the credit check.
  assign unused_ok = ^{pe_idx, fifo_full};

endmodule

// File: tb/tb_pe_part_sum_bcast_ctrl.sv
// Testbench for pe_part_sum_bcast_ctrl: table of directed passes with
// hand-computed sends, plus abort and mid-pass reset sequences.
module tb_pe_part_sum_bcast_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  pe_idx;
  logic        part_sum_done;
  logic [5:0]  rank_no;
  logic [7:0]  base_addr;
  logic        abort;
  logic        busy;
  logic        fin_tx_part_sum;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        send_valid;
  logic        send_ready;
  logic [15:0] send_data;
  logic [7:0]  send_addr;

  pe_part_sum_bcast_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pe_idx          (pe_idx),
    .part_sum_done   (part_sum_done),
    .rank_no         (rank_no),
    .base_addr       (base_addr),
    .abort           (abort),
    .busy            (busy),
    .fin_tx_part_sum (fin_tx_part_sum),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .send_valid      (send_valid),
    .send_ready      (send_ready),
    .send_data       (send_data),
    .send_addr       (send_addr)
  );

  typedef struct packed {
    logic [5:0]        rank;
    logic [7:0]        base;
    logic [7:0]        stall_at;
    logic [7:0]        stall_len;
    logic [2:0]        n_exp;
    logic [3:0][15:0]  data;
    logic [3:0][7:0]   exp_addr;
    logic [3:0][15:0]  exp_data;
  } vec_t;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [15:0] rf [64];

  int          pop_cnt, rd_seen, fin_cnt, fin_cyc, first_valid_cyc;
  int          last_pop_cyc, busy_cnt, max_out;
  logic        hold_q;
  logic [24:0] held;
  logic [23:0] got_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file secondary port model: 1-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= rf[rd_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    pop_cnt = 0; rd_seen = 0; fin_cnt = 0; fin_cyc = -1; first_valid_cyc = -1;
    last_pop_cyc = -1; busy_cnt = 0; max_out = 0; hold_q = 1'b0;
    got_q.delete();
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_q) chk("hold_stable", 32'(held), 32'({send_valid, send_addr, send_data}));
      hold_q = send_valid && !send_ready && !abort;
      held   = {send_valid, send_addr, send_data};
      if (send_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (send_valid && send_ready) begin
        got_q.push_back({send_addr, send_data});
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      if (rd_en) begin
        chk("rd_addr_seq", 32'(rd_addr), 32'(rd_seen));
        rd_seen++;
      end
      if (fin_tx_part_sum) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (rd_seen - pop_cnt > max_out) max_out = rd_seen - pop_cnt;
    end else begin
      hold_q = 1'b0;
    end
  end

  function automatic vec_t mk(input logic [5:0] r, input logic [7:0] b,
                              input logic [7:0] sa, input logic [7:0] sl,
                              input logic [2:0] n, input logic [3:0][15:0] d,
                              input logic [3:0][7:0] ea, input logic [3:0][15:0] ed);
    vec_t v;
    v.rank = r; v.base = b; v.stall_at = sa; v.stall_len = sl; v.n_exp = n;
    v.data = d; v.exp_addr = ea; v.exp_data = ed;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int  start;
    int  npulse;
    bit  done_flag;
    clr_mon();
    for (int i = 0; i < 4; i++) rf[i] = v.data[i];
    npulse    = (v.rank == 0) ? 1 : int'(v.rank);
    start     = 0;
    done_flag = 1'b0;
    for (int t = 0; t < 80 && !done_flag; t++) begin
      @(posedge clk); #1;
      if (t == 0) start = cyc;
      rank_no       = v.rank;
      base_addr     = v.base;
      part_sum_done = (t < npulse);
      send_ready    = !(t >= int'(v.stall_at) && t < int'(v.stall_at) + int'(v.stall_len));
      if (fin_cnt > 0 && cyc > fin_cyc + 3) done_flag = 1'b1;
    end
    part_sum_done = 1'b0;
    send_ready    = 1'b1;
    chk({nm, "_fin_count"}, 32'(fin_cnt), 32'd1);
    chk({nm, "_reads"}, 32'(rd_seen), 32'(v.rank));
    chk({nm, "_n_sent"}, 32'(got_q.size()), 32'(v.n_exp));
    for (int i = 0; i < int'(v.n_exp); i++)
      if (i < got_q.size())
        chk({nm, "_send"}, 32'(got_q[i]), 32'({v.exp_addr[i], v.exp_data[i]}));
    if (v.rank != 0) chk({nm, "_first_valid_lat"}, 32'(first_valid_cyc - start), 32'd6);
    else             chk({nm, "_no_valid"}, 32'(first_valid_cyc), 32'hFFFF_FFFF);
    if (v.n_exp != 0) chk({nm, "_fin_after_pop"}, 32'(fin_cyc - last_pop_cyc), 32'd1);
    else              chk({nm, "_fin_lat"}, 32'(fin_cyc - start), 32'd1);
    chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(fin_cyc - start));
`ifndef PSUM_BCAST_SKIP_ZERO_EN
    chk({nm, "_max_buffered"}, 32'(max_out <= 2), 32'd1);
`endif
  endtask

  vec_t vecs [6];

  initial begin
    int  rd_at_abort;
    bit  aborted;

    vecs[0] = mk(6'd4, 8'h10, 8'd255, 8'd0, 3'd4,
                 {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                 {8'h13, 8'h12, 8'h11, 8'h10},
                 {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    vecs[1] = mk(6'd4, 8'h10, 8'd7, 8'd5, 3'd4,
                 {16'hA004, 16'hA003, 16'hA002, 16'hA001},
                 {8'h13, 8'h12, 8'h11, 8'h10},
                 {16'hA004, 16'hA003, 16'hA002, 16'hA001});
    vecs[2] = mk(6'd3, 8'hFE, 8'd255, 8'd0, 3'd3,
                 {16'h0000, 16'h0DAD, 16'h0CAF, 16'h0BEE},
                 {8'h00, 8'h00, 8'hFF, 8'hFE},
                 {16'h0000, 16'h0DAD, 16'h0CAF, 16'h0BEE});
    vecs[3] = mk(6'd0, 8'h55, 8'd255, 8'd0, 3'd0, '0, '0, '0);
    vecs[4] = mk(6'd1, 8'h80, 8'd255, 8'd0, 3'd1,
                 {48'h0, 16'h7FFF}, {24'h0, 8'h80}, {48'h0, 16'h7FFF});
`ifdef PSUM_BCAST_SKIP_ZERO_EN
    vecs[5] = mk(6'd3, 8'h20, 8'd255, 8'd0, 3'd2,
                 {16'h0, 16'h0007, 16'h0000, 16'h0005},
                 {16'h0, 8'h22, 8'h20},
                 {32'h0, 16'h0007, 16'h0005});
`else
    vecs[5] = mk(6'd3, 8'h20, 8'd255, 8'd0, 3'd3,
                 {16'h0, 16'h0007, 16'h0000, 16'h0005},
                 {8'h00, 8'h22, 8'h21, 8'h20},
                 {16'h0, 16'h0007, 16'h0000, 16'h0005});
`endif

    rst_n = 1'b0; pe_idx = 6'd5; part_sum_done = 1'b0; rank_no = '0;
    base_addr = '0; abort = 1'b0; send_ready = 1'b1; rd_data = '0;
    clr_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fin", 32'(fin_tx_part_sum), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_send_valid", 32'(send_valid), 32'd0);
    chk("rst_send_data", 32'(send_data), 32'd0);
    chk("rst_send_addr", 32'(send_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort after two sends, with a same-cycle part_sum_done.
    clr_mon();
    for (int i = 0; i < 4; i++) rf[i] = 16'hB000 + 16'(i);
    aborted = 1'b0;
    rd_at_abort = 0;
    rank_no = 6'd4; base_addr = 8'h40;
    for (int t = 0; t < 40 && !aborted; t++) begin
      @(posedge clk); #1;
      part_sum_done = (t < 4);
      send_ready    = 1'b1;
      if (pop_cnt == 2) begin
        abort         = 1'b1;
        part_sum_done = 1'b1;
        send_ready    = 1'b0;
        aborted       = 1'b1;
        rd_at_abort   = rd_seen;
      end
    end
    chk("abort_reached", 32'(aborted), 32'd1);
    @(posedge clk); #1;
    abort = 1'b0; part_sum_done = 1'b0; send_ready = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_send_valid", 32'(send_valid), 32'd0);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_pops", 32'(pop_cnt), 32'd2);
    chk("abort_no_fin", 32'(fin_cnt), 32'd0);
    chk("abort_no_reads", 32'(rd_seen), 32'(rd_at_abort));
    if (got_q.size() >= 2) begin
      chk("abort_send0", 32'(got_q[0]), 32'h40B000);
      chk("abort_send1", 32'(got_q[1]), 32'h41B001);
    end
    run_vec(vecs[0], "post_abort");

    // Reset in the middle of a pass.
    clr_mon();
    rank_no = 6'd4; base_addr = 8'h10;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      part_sum_done = (t < 4);
    end
    rst_n = 1'b0; part_sum_done = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_send_valid", 32'(send_valid), 32'd0);
    chk("midrst_send_data", 32'(send_data), 32'd0);
    chk("midrst_send_addr", 32'(send_addr), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_fin", 32'(fin_cnt), 32'd0);
    chk("midrst_no_send", 32'(pop_cnt), 32'd0);
    run_vec(vecs[2], "post_reset");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
